// File: rtl/fifo_fwft_burst_reader.sv
// fifo_fwft_burst_reader
//   Drain side of a first-word-fall-through FIFO. Words are popped and sent out on a
//   valid/ready stream in bursts of a runtime length, with m_last on the final beat.
//   A burst starts when the FIFO holds a full burst, when a partial burst has waited
//   long enough (timeout), or while a flush is pending.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   fifo_empty     FIFO empty; fifo_dataout valid when low
//   fifo_dataout   FWFT head word
//   fifo_count     FIFO occupancy (18 bits)
//   fifo_rden      pop strobe (= m_valid & m_ready)
//   burst_len      requested burst length, sampled at burst start (0 -> 1, clamped to C_MAX_BURST)
//   flush          one-cycle pulse: drain the FIFO completely in bursts
//   m_valid/m_ready/m_data/m_last  output stream
//   burst_active   high while in BURST
//   flush_pending  a flush is in progress
//   bursts_done    completed-burst counter (wraps)

module fifo_fwft_burst_reader #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_MAX_BURST  = 16,
  parameter int C_TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [C_DATA_WIDTH-1:0] fifo_dataout,
  input  logic [17:0]             fifo_count,
  output logic                    fifo_rden,
  input  logic [7:0]              burst_len,
  input  logic                    flush,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    burst_active,
  output logic                    flush_pending,
  output logic [31:0]             bursts_done
);

  localparam int LW = $clog2(C_MAX_BURST) + 1;
  // Timer only needs to reach C_TIMEOUT-1; the burst starts on that value.
  localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [8:0]    MAXB     = 9'(C_MAX_BURST);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [LW-1:0] remaining;
  logic [TW-1:0] tmo;

  logic [8:0]    len_clamp;
  logic [LW-1:0] eff_len;
  logic [LW-1:0] part_len;
  logic          count_ge;
  logic          count_nz;
  logic          tmo_hit;
  logic          hs;

  // Clamp burst_len to 1..C_MAX_BURST in 9 bits so C_MAX_BURST=256 still fits.
  always_comb begin
    len_clamp = {1'b0, burst_len};
    if (burst_len == 8'd0)
      len_clamp = 9'd1;
    else if ({1'b0, burst_len} > MAXB)
      len_clamp = MAXB;
  end

  assign eff_len  = len_clamp[LW-1:0];
  assign count_ge = fifo_count >= 18'(eff_len);
  assign count_nz = fifo_count != 18'd0;
  // Partial burst length: only used when count < eff_len, so count fits in LW bits.
  assign part_len = count_ge ? eff_len : fifo_count[LW-1:0];
  assign tmo_hit  = tmo == TMO_LAST;

  // Stream side is a direct pass-through of the FWFT head while bursting.
  assign burst_active = state == BURST;
  assign m_valid      = burst_active & ~fifo_empty;
  assign m_data       = fifo_dataout;
  assign m_last       = m_valid & (remaining == LW'(1));
  assign fifo_rden    = m_valid & m_ready;
  assign hs           = fifo_rden;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      tmo           <= '0;
      flush_pending <= 1'b0;
      bursts_done   <= '0;
    end else begin
      // A new pulse wins over the drained condition so it is never lost.
      if (flush)
        flush_pending <= 1'b1;
      else if (state == IDLE && !count_nz && fifo_empty)
        flush_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (count_ge) begin
            remaining <= eff_len;
            tmo       <= '0;
            state     <= BURST;
          end else if (count_nz && (flush_pending || tmo_hit)) begin
            remaining <= part_len;
            tmo       <= '0;
            state     <= BURST;
          end else if (count_nz) begin
            tmo <= tmo + TW'(1);
          end else begin
            tmo <= '0;
          end
        end
        BURST: begin
          tmo <= '0;
          // An empty FIFO mid-burst just stalls; the burst is never cut short.
          if (hs) begin
            remaining <= remaining - LW'(1);
            if (remaining == LW'(1)) begin
              bursts_done <= bursts_done + 32'd1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fwft_burst_reader.sv
module tb_fifo_fwft_burst_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic [127:0] fifo_dataout;
  logic [17:0]  fifo_count;
  logic         fifo_rden;
  logic [7:0]   burst_len;
  logic         flush;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         burst_active;
  logic         flush_pending;
  logic [31:0]  bursts_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // FWFT FIFO model feeding the DUT
  logic [127:0] mem [256];
  int           wp = 0;
  int           rp = 0;
  logic         wr_en;
  logic [127:0] wr_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      rp <= wp;
    end else begin
      if (wr_en) begin
        mem[wp % 256] <= wr_data;
        wp <= wp + 1;
      end
      if (fifo_rden) rp <= rp + 1;
    end
  end

  assign fifo_count   = 18'(wp - rp);
  assign fifo_empty   = (wp == rp);
  assign fifo_dataout = mem[rp % 256];

  fifo_fwft_burst_reader #(
    .C_DATA_WIDTH(128),
    .C_MAX_BURST (16),
    .C_TIMEOUT   (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_dataout (fifo_dataout),
    .fifo_count   (fifo_count),
    .fifo_rden    (fifo_rden),
    .burst_len    (burst_len),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .burst_active (burst_active),
    .flush_pending(flush_pending),
    .bursts_done  (bursts_done)
  );

  // Writes one word into the FIFO model and records what should come out.
  task automatic push_word(input logic [127:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back('{d, last});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; m_ready = 1'b0; burst_len = 8'd4;
    wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, m_last, fifo_rden, burst_active, flush_pending} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {m_valid, m_last, fifo_rden, burst_active, flush_pending});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bursts_done !== 32'd0) begin
      errors++; $display("FAIL reset_bursts_done: got %0d expected 0", bursts_done);
    end
    checks++;
    if ({m_valid, burst_active} !== 2'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 00", {m_valid, burst_active});
    end
  endtask

  task automatic test_full_burst();
    int bd0;
    bd0 = bursts_done;
    burst_len = 8'd4; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(128'(i), i == 3);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      m_ready = 1'b1; #1;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t1_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL t1_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bursts_done !== 32'(bd0 + 1)) begin
      errors++; $display("FAIL t1_bursts_done: got %0d expected %0d", bursts_done, bd0 + 1);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int w;
    burst_len = 8'd4; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, 32'(16 + i)}, i == 2);
    // Timer runs from the first write: decision 64 clocks after it, 62 idle samples from here.
    w = 0;
    while (!m_valid && w < 100) begin
      w++; @(negedge clk);
    end
    checks++;
    if (w != 62) begin
      errors++; $display("FAIL t2_wait_cycles: got %0d expected 62", w);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      m_ready = 1'b1; #1;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t2_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL t2_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    burst_len = 8'd8; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word({$urandom, $urandom, $urandom, 32'(32 + i)}, i == 7);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      m_ready = (c % 2) == 0; #1;
      checks++;
      if (fifo_rden !== (m_valid & m_ready) || (fifo_rden && fifo_empty)) begin
        errors++; $display("FAIL t3_rden: got %b expected %b", fifo_rden, m_valid & m_ready);
      end
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t3_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL t3_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    int bd0;
    bd0 = bursts_done;
    burst_len = 8'd4; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom, $urandom, 32'(48 + i)}, i >= 3);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      flush   = (c == 0);
      m_ready = 1'b1; #1;
      if (c == 1) begin
        checks++;
        if (flush_pending !== 1'b1) begin
          errors++; $display("FAIL t4_flush_set: got %b expected 1", flush_pending);
        end
      end
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t4_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    flush = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL t4_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    checks++;
    if (flush_pending !== 1'b0) begin
      errors++; $display("FAIL t4_flush_clear: got %b expected 0", flush_pending);
    end
    checks++;
    if (bursts_done !== 32'(bd0 + 2)) begin
      errors++; $display("FAIL t4_bursts_done: got %0d expected %0d", bursts_done, bd0 + 2);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_len_clamp();
    int bd0;
    bd0 = bursts_done;
    burst_len = 8'd0; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, 32'(64 + i)}, 1'b1);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      m_ready = 1'b1; #1;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t5_len0_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || bursts_done !== 32'(bd0 + 3)) begin
      errors++; $display("FAIL t5_len0_bursts: got %0d (left %0d) expected %0d",
                         bursts_done, exp_q.size(), bd0 + 3);
      exp_q.delete();
    end
    // 200 clamps to 16: one full burst, then the last 4 words leave on the timeout.
    burst_len = 8'd200; m_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      push_word({$urandom, $urandom, $urandom, 32'(80 + i)}, i == 15 || i == 19);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      if (c == 3) burst_len = 8'd2;     // mid-burst change must not shorten this burst
      if (c == 6) burst_len = 8'd200;
      m_ready = 1'b1; #1;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t5_clamp_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || bursts_done !== 32'(bd0 + 5)) begin
      errors++; $display("FAIL t5_clamp_bursts: got %0d (left %0d) expected %0d",
                         bursts_done, exp_q.size(), bd0 + 5);
      exp_q.delete();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    burst_len = 8'd4; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, 32'(128 + i)}, i == 3);
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      m_ready = 1'b1; #1;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++; n++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL t6_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, m_last, burst_active, flush_pending} !== 4'b0 || bursts_done !== 32'd0) begin
      errors++; $display("FAIL t6_reset: got v/l/a/f=%b done=%0d expected 0000 done=0",
                         {m_valid, m_last, burst_active, flush_pending}, bursts_done);
    end
    rst = 1'b0;
    exp_q.delete();
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic prev_last_hs;
    burst_len = 8'd2; m_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      push_word({$urandom, $urandom, $urandom, 32'(160 + i)}, (i % 2) == 1);
    prev_last_hs = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      m_ready = 1'b1; #1;
      if (prev_last_hs) begin
        checks++;
        if (m_valid !== 1'b0 || burst_active !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap: got valid=%b active=%b expected 0 0",
                             m_valid, burst_active);
        end
      end
      prev_last_hs = m_valid & m_ready & m_last;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); checks++;
        if ({m_last, m_data} !== {e.last, e.data}) begin
          errors++; $display("FAIL b2b_beat: got last=%b data=%0h expected last=%b data=%0h",
                             m_last, m_data, e.last, e.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || bursts_done !== 32'd3) begin
      errors++; $display("FAIL b2b_bursts: got %0d (left %0d) expected 3", bursts_done, exp_q.size());
      exp_q.delete();
    end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_backpressure();
    test_flush();
    test_len_clamp();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
